// File: rtl/active_debug_rx_pkg.sv
// Shared constants and types for the Active Debug Port receiver.
package active_pkg;

    localparam logic [7:0]  ACTIVE_SYNC_BYTE = 8'h7F;
    localparam logic [1:0]  ACTIVE_CHAN_TAG  = 2'b01;
    localparam int unsigned ACTIVE_MAX_TEXT  = 62;
    localparam int unsigned ACTIVE_MSG_BYTES = 64;

    typedef enum logic [1:0] {
        HUNT,
        CHAN,
        PAYLOAD
    } active_state_e;

    typedef logic [ACTIVE_MSG_BYTES-1:0][7:0] active_msg_t;

endpackage

// File: rtl/active_debug_rx_if.sv
// Serial input pins and rebuilt-message outputs of the Active Debug receiver.
interface active_debug_rx_if;
    import active_pkg::*;

    logic        active_clock;
    logic        active_data;
    active_msg_t rx_message;
    logic [5:0]  rx_channel;
    logic [5:0]  rx_length;
    logic        rx_valid;
    logic        rx_error;
    logic        rx_busy;

    modport slave (
        input  active_clock, active_data,
        output rx_message, rx_channel, rx_length, rx_valid, rx_error, rx_busy
    );

    modport master (
        output active_clock, active_data,
        input  rx_message, rx_channel, rx_length, rx_valid, rx_error, rx_busy
    );

endinterface

// File: rtl/active_debug_rx_sync.sv
// Synchronises the serial clock/data pair and flags serial-clock rising edges.
module active_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_clock,
    input  logic active_data,
    output logic bit_event,
    output logic bit_data
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], active_clock};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], active_data};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    // Data is taken from the same depth as the clock so both see equal latency.
    assign bit_event = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    assign bit_data  = data_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/active_debug_rx.sv
// Active Debug Port receiver: hunts for the sync byte, deframes channel and text,
// and rebuilds the zero-surrounded 64-byte message.
module active_debug_rx
    import active_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input logic              clk,
    input logic              rst_n,
    active_debug_rx_if.slave bus
);

    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

    logic bit_event;
    logic bit_data;

    active_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .active_clock (bus.active_clock),
        .active_data  (bus.active_data),
        .bit_event    (bit_event),
        .bit_data     (bit_data)
    );

    active_state_e    state_q, state_d;
    logic [6:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    active_msg_t      wb_q, wb_d;
    logic [5:0]       count_q, count_d;
    logic [5:0]       chan_q, chan_d;
    logic [IdleW-1:0] idle_q, idle_d;
    active_msg_t      msg_q, msg_d;
    logic [5:0]       out_chan_q, out_chan_d;
    logic [5:0]       out_len_q, out_len_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;

    logic [7:0] byte_in;
    logic       byte_done;
    logic       timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            wb_q       <= '0;
            count_q    <= '0;
            chan_q     <= '0;
            idle_q     <= '0;
            msg_q      <= '0;
            out_chan_q <= '0;
            out_len_q  <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            wb_q       <= wb_d;
            count_q    <= count_d;
            chan_q     <= chan_d;
            idle_q     <= idle_d;
            msg_q      <= msg_d;
            out_chan_q <= out_chan_d;
            out_len_q  <= out_len_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    // The window and the byte collector share one shift register.
    assign byte_in   = {shift_q, bit_data};
    assign byte_done = bit_event && (bit_cnt_q == 3'd7);
    assign timeout   = !bit_event && (idle_q == IdleW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        wb_d       = wb_q;
        count_d    = count_q;
        chan_d     = chan_q;
        idle_d     = bit_event ? '0 : idle_q + IdleW'(1);
        msg_d      = msg_q;
        out_chan_d = out_chan_q;
        out_len_d  = out_len_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;

        if (bit_event) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        unique case (state_q)
            HUNT: begin
                idle_d = '0;
                if (bit_event && byte_in == ACTIVE_SYNC_BYTE) begin
                    state_d   = CHAN;
                    bit_cnt_d = '0;
                    wb_d      = '0;
                    count_d   = '0;
                end
            end
            CHAN: begin
                if (byte_done) begin
                    if (byte_in[7:6] == ACTIVE_CHAN_TAG) begin
                        chan_d  = byte_in[5:0];
                        state_d = PAYLOAD;
                    end else begin
                        error_d = 1'b1;
                        state_d = HUNT;
                    end
                end
            end
            PAYLOAD: begin
                if (byte_done) begin
                    if (byte_in == 8'h00) begin
                        msg_d      = wb_q;
                        out_chan_d = chan_q;
                        out_len_d  = count_q;
                        valid_d    = 1'b1;
                        state_d    = HUNT;
                    end else if (count_q == 6'(ACTIVE_MAX_TEXT)) begin
                        error_d = 1'b1;
                        state_d = HUNT;
                    end else begin
                        // Text arrives highest index first, so older bytes move up.
                        wb_d    = {wb_q[ACTIVE_MSG_BYTES-2:1], byte_in, 8'h00};
                        count_d = count_q + 6'd1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        if (state_q != HUNT && timeout) begin
            error_d = 1'b1;
            state_d = HUNT;
            shift_d = '0;
            idle_d  = '0;
        end
    end

    always_comb begin
        bus.rx_message = msg_q;
        bus.rx_channel = out_chan_q;
        bus.rx_length  = out_len_q;
        bus.rx_valid   = valid_q;
        bus.rx_error   = error_q;
        bus.rx_busy    = (state_q != HUNT);
    end

endmodule

// File: tb/tb_active_debug_rx.sv
// Directed bench for active_debug_rx: framing, alignment, errors, timeout, reset.
module tb_active_debug_rx;
    import active_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   valid_cnt;
    int   error_cnt;
    active_msg_t exp_msg;

    active_debug_rx_if bus ();

    active_debug_rx #(
        .TIMEOUT_CYCLES (1024),
        .SYNC_STAGES    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_valid) valid_cnt <= valid_cnt + 1;
        if (bus.rx_error) error_cnt <= error_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.active_data  = b;
        bus.active_clock = 1'b0;
        repeat (3) @(negedge clk);
        bus.active_clock = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        valid_cnt = 0;
        error_cnt = 0;
        rst_n = 1'b0;
        bus.active_clock = 1'b0;
        bus.active_data  = 1'b0;
        idle(3);
        check_eq("rst_valid", 512'(bus.rx_valid), 512'(0));
        check_eq("rst_error", 512'(bus.rx_error), 512'(0));
        check_eq("rst_busy", 512'(bus.rx_busy), 512'(0));
        check_eq("rst_len", 512'(bus.rx_length), 512'(0));
        check_eq("rst_msg", 512'(bus.rx_message), 512'(0));
        rst_n = 1'b1;
        idle(3);

        // "HI" on channel 5
        send_byte(8'h7F); send_byte(8'h45); send_byte(8'h49); send_byte(8'h48);
        send_byte(8'h00);
        idle(6);
        exp_msg = '0;
        exp_msg[1] = 8'h48;
        exp_msg[2] = 8'h49;
        check_eq("hi_valid_cnt", 512'(valid_cnt), 512'(1));
        check_eq("hi_error_cnt", 512'(error_cnt), 512'(0));
        check_eq("hi_chan", 512'(bus.rx_channel), 512'(5));
        check_eq("hi_len", 512'(bus.rx_length), 512'(2));
        check_eq("hi_msg", 512'(bus.rx_message), 512'(exp_msg));
        check_eq("hi_busy", 512'(bus.rx_busy), 512'(0));

        // misaligned lead-in bits
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_byte(8'h7F); send_byte(8'h40); send_byte(8'h41); send_byte(8'h00);
        idle(6);
        exp_msg = '0;
        exp_msg[1] = 8'h41;
        check_eq("align_valid_cnt", 512'(valid_cnt), 512'(2));
        check_eq("align_error_cnt", 512'(error_cnt), 512'(0));
        check_eq("align_chan", 512'(bus.rx_channel), 512'(0));
        check_eq("align_len", 512'(bus.rx_length), 512'(1));
        check_eq("align_msg", 512'(bus.rx_message), 512'(exp_msg));

        // bad channel tag, then channel 63
        send_byte(8'h7F); send_byte(8'h85);
        idle(6);
        check_eq("badtag_error_cnt", 512'(error_cnt), 512'(1));
        check_eq("badtag_busy", 512'(bus.rx_busy), 512'(0));
        send_byte(8'h7F); send_byte(8'h7F); send_byte(8'h31); send_byte(8'h00);
        idle(6);
        exp_msg = '0;
        exp_msg[1] = 8'h31;
        check_eq("ch63_valid_cnt", 512'(valid_cnt), 512'(3));
        check_eq("ch63_chan", 512'(bus.rx_channel), 512'(63));
        check_eq("ch63_len", 512'(bus.rx_length), 512'(1));
        check_eq("ch63_msg", 512'(bus.rx_message), 512'(exp_msg));

        // timeout mid-payload
        send_byte(8'h7F); send_byte(8'h4A); send_byte(8'h41);
        check_eq("to_busy_before", 512'(bus.rx_busy), 512'(1));
        idle(1100);
        check_eq("to_error_cnt", 512'(error_cnt), 512'(2));
        check_eq("to_busy_after", 512'(bus.rx_busy), 512'(0));
        check_eq("to_valid_cnt", 512'(valid_cnt), 512'(3));
        check_eq("to_chan_hold", 512'(bus.rx_channel), 512'(63));
        check_eq("to_msg_hold", 512'(bus.rx_message), 512'(exp_msg));

        // overflow: 63 text bytes
        send_byte(8'h7F); send_byte(8'h41);
        for (int i = 0; i < 63; i++) send_byte(8'h41);
        send_byte(8'h00);
        idle(6);
        check_eq("ovf_error_cnt", 512'(error_cnt), 512'(3));
        check_eq("ovf_valid_cnt", 512'(valid_cnt), 512'(3));
        check_eq("ovf_len_hold", 512'(bus.rx_length), 512'(1));

        // maximum: 62 text bytes
        send_byte(8'h7F); send_byte(8'h41);
        for (int i = 0; i < 62; i++) send_byte(8'h41);
        send_byte(8'h00);
        idle(6);
        exp_msg = '0;
        for (int k = 1; k <= 62; k++) exp_msg[k] = 8'h41;
        check_eq("max_valid_cnt", 512'(valid_cnt), 512'(4));
        check_eq("max_error_cnt", 512'(error_cnt), 512'(3));
        check_eq("max_chan", 512'(bus.rx_channel), 512'(1));
        check_eq("max_len", 512'(bus.rx_length), 512'(62));
        check_eq("max_msg", 512'(bus.rx_message), 512'(exp_msg));

        // reset mid-payload
        send_byte(8'h7F); send_byte(8'h42); send_byte(8'h43);
        check_eq("rmid_busy_before", 512'(bus.rx_busy), 512'(1));
        #1;
        rst_n = 1'b0;
        bus.active_clock = 1'b0;
        #1;
        check_eq("rmid_busy", 512'(bus.rx_busy), 512'(0));
        check_eq("rmid_len", 512'(bus.rx_length), 512'(0));
        check_eq("rmid_chan", 512'(bus.rx_channel), 512'(0));
        check_eq("rmid_msg", 512'(bus.rx_message), 512'(0));
        idle(3);
        rst_n = 1'b1;
        idle(3);
        check_eq("rmid_valid_cnt", 512'(valid_cnt), 512'(4));
        check_eq("rmid_error_cnt", 512'(error_cnt), 512'(3));

        send_byte(8'h7F); send_byte(8'h42); send_byte(8'h5A); send_byte(8'h00);
        idle(6);
        exp_msg = '0;
        exp_msg[1] = 8'h5A;
        check_eq("post_valid_cnt", 512'(valid_cnt), 512'(5));
        check_eq("post_chan", 512'(bus.rx_channel), 512'(2));
        check_eq("post_msg", 512'(bus.rx_message), 512'(exp_msg));

        // back-to-back "A" then "B"
        send_byte(8'h7F); send_byte(8'h43); send_byte(8'h41); send_byte(8'h00);
        send_byte(8'h7F); send_byte(8'h44); send_byte(8'h42); send_byte(8'h00);
        idle(6);
        exp_msg = '0;
        exp_msg[1] = 8'h42;
        check_eq("b2b_valid_cnt", 512'(valid_cnt), 512'(7));
        check_eq("b2b_error_cnt", 512'(error_cnt), 512'(3));
        check_eq("b2b_chan", 512'(bus.rx_channel), 512'(4));
        check_eq("b2b_len", 512'(bus.rx_length), 512'(1));
        check_eq("b2b_msg", 512'(bus.rx_message), 512'(exp_msg));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/active_debug_rx.md
Name: active_debug_rx

Overview:
Receiver for the Active Debug Port serial protocol. It samples ACTIVE_CLOCK/ACTIVE_DATA from an external transmitter, deframes packets, and rebuilds the zero-surrounded text message plus channel number. The rebuilt message uses the same 64-byte layout that the transmitter accepts. Used for loopback checking and for on-chip capture of debug traffic from other FPGAs or devices.

Parameters:
TIMEOUT_CYCLES, 1024, SYS_CLOCK cycles with no ACTIVE_CLOCK rising edge before a packet in progress is aborted.
SYNC_STAGES, 2, synchroniser depth applied to ACTIVE_CLOCK and ACTIVE_DATA (minimum 2).

Ports:
SYS_CLOCK  input  1  block clock; all logic on its rising edge.
RESET_N  input  1  asynchronous, active-low reset.
ACTIVE_CLOCK  input  1  serial clock from transmitter; asynchronous to SYS_CLOCK.
ACTIVE_DATA  input  1  serial data; valid at ACTIVE_CLOCK rising edge.
RX_MESSAGE  output  [63:0][7:0]  last good message; [0]=0, text in [1..n], [n+1]=0, rest 0.
RX_CHANNEL  output  6  channel of last good message.
RX_LENGTH  output  6  text byte count n of last good message, 0..62.
RX_VALID  output  1  one-cycle pulse when RX_* are updated.
RX_ERROR  output  1  one-cycle pulse when a packet is discarded.
RX_BUSY  output  1  high from header match until the packet completes or aborts.

Behaviour:
- Reset: one clock; RESET_N is asynchronous, active-low. While RESET_N=0, all outputs are 0, synchronisers are cleared, and state is HUNT. Reset mid-packet discards the packet with no RX_ERROR.
- Input conditioning:
  - ACTIVE_CLOCK and ACTIVE_DATA each pass through SYNC_STAGES flops.
  - A bit event is a 0->1 transition at the last ACTIVE_CLOCK stage. Data is taken from the same-depth ACTIVE_DATA stage in that cycle.
  - Constraint: the ACTIVE_CLOCK high and low phases are each >=2 SYS_CLOCK periods.
- Bits are MSB first. Packet wire order:
  - 0x7F
  - 0x40|channel
  - text bytes in descending index order (msg[n] first)
  - 0x00
- States:
  - HUNT: shift every bit into an 8-bit window. Window==0x7F -> CHAN, clear the bit counter, clear the working buffer, set RX_BUSY. No timeout is applied in HUNT.
  - CHAN: collect 8 bits. Byte[7:6]==2'b01 -> latch byte[5:0], go to PAYLOAD. Otherwise pulse RX_ERROR and go to HUNT.
  - PAYLOAD: collect bytes.
    - Non-zero byte: the working buffer shifts up one index (wb[k+1]<=wb[k] for k>=1), the byte is written to wb[1], and the count increments.
    - 0x00 byte: commit.
- Commit:
  - RX_MESSAGE<=wb, RX_CHANNEL<=latched channel, RX_LENGTH<=count.
  - RX_VALID=1 for exactly one cycle, in the cycle after the bit event carrying bit 0 of the terminator.
  - Return to HUNT; RX_BUSY=0 in the same cycle as RX_VALID.
- Overflow: a 63rd non-zero text byte pulses RX_ERROR and returns to HUNT. Outputs are unchanged.
- Timeout: in CHAN or PAYLOAD, an idle counter reloads on every bit event. When it reaches TIMEOUT_CYCLES: pulse RX_ERROR, go to HUNT, partial bits are discarded.
- RX_MESSAGE, RX_CHANNEL and RX_LENGTH hold until the next commit. Reception during the hold is unaffected. There is no backpressure.
- Empty message (0x7F, 0x4c, 0x00): commits with RX_LENGTH=0 and RX_MESSAGE all zero.
- Data bits that follow a commit without an intervening idle period are hunted bit-by-bit; back-to-back packets must both be received.

Decomposition:
- Package active_pkg:
  - ACTIVE_SYNC_BYTE=8'h7F
  - ACTIVE_CHAN_TAG=2'b01
  - ACTIVE_MAX_TEXT=62
  - ACTIVE_MSG_BYTES=64
  - state enum {HUNT, CHAN, PAYLOAD}
- One sub-module, active_rx_sync: a SYNC_STAGES-deep synchroniser for clock and data with rising-edge detect. Outputs bit_event and bit_data.

Test Plan:
- Text "HI" on channel 5: wire bytes 7F,45,49,48,00 -> single RX_VALID; RX_CHANNEL=5, RX_LENGTH=2; RX_MESSAGE[0]=00, [1]=48, [2]=49, [3..63]=00.
- Bits 1,0,1 followed by the 7F,40,41,00 packet on channel 0 -> alignment found; RX_LENGTH=1, [1]=41, RX_ERROR never asserted.
- 7F then 0x85 (bad channel tag) -> RX_ERROR pulse; then 7F,7F,31,00 -> valid with RX_CHANNEL=63, [1]=31.
- 7F,4A,41 followed by 1100 idle cycles -> RX_ERROR once, RX_BUSY falls, prior RX_* unchanged.
- 7F,41 then 63 bytes of 0x41, then 00 -> RX_ERROR on the 63rd byte, no RX_VALID. Then 62 bytes of 0x41 and 00 -> valid, RX_LENGTH=62, [63]=00.
- RESET_N pulsed low mid-PAYLOAD -> outputs 0 immediately, no RX_VALID or RX_ERROR. The next full packet is received correctly. A back-to-back pair "A"/"B" -> two RX_VALID pulses.
